// File: rtl/brew_timer_bank.sv
// -----------------------------------------------------------------------------
// brew_timer_bank
//
// Multi-channel countdown timer bank for the coffee-maker controller. One
// shared prescaler derives a slow tick from the system clock. Each channel
// counts a per-start duration (in ticks) down to zero and drives an actuator
// enable plus a sticky expiry flag towards the control FSM.
//
// Parameters
//   NUM_CH    : number of independent channels (1..16)
//   WIDTH     : bits of the per-channel duration / remaining counter
//   TICK_DIV  : clock cycles per tick (>= 2)
//   RETRIGGER : 1 = a start edge while active reloads the duration,
//               0 = a start edge while active is ignored
//
// Ports
//   clk_100MHz  in   system clock, all logic on the rising edge
//   rst_n       in   synchronous reset, active low
//   start       in   [NUM_CH]        start request, rising edge detected here
//   abort       in   [NUM_CH]        level, returns the channel to IDLE
//   pause       in   [NUM_CH]        level, freezes the countdown
//   reload_mode in   [NUM_CH]        1 = auto-reload at zero, 0 = one-shot
//   duration    in   [NUM_CH*WIDTH]  channel k at [k*WIDTH +: WIDTH]
//   on          out  [NUM_CH]        channel active (RUN or PAUSE)
//   t_expired   out  [NUM_CH]        sticky expiry flag (one-shot channels)
//   done_pulse  out  [NUM_CH]        one-cycle pulse when a channel hits zero
//   remaining   out  [NUM_CH*WIDTH]  remaining ticks, same packing as duration
//   tick        out                  shared prescaler tick
// -----------------------------------------------------------------------------
module brew_timer_bank #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int TICK_DIV  = 100_000_000,
  parameter int RETRIGGER = 0
) (
  input  logic                      clk_100MHz,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         abort,
  input  logic [NUM_CH-1:0]         pause,
  input  logic [NUM_CH-1:0]         reload_mode,
  input  logic [NUM_CH*WIDTH-1:0]   duration,
  output logic [NUM_CH-1:0]         on,
  output logic [NUM_CH-1:0]         t_expired,
  output logic [NUM_CH-1:0]         done_pulse,
  output logic [NUM_CH*WIDTH-1:0]   remaining,
  output logic                      tick
);

  localparam int              CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   PRESC_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   PRESC_ONE = CW'(1);
  localparam logic [WIDTH-1:0] REM_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } ch_state_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [CW-1:0]     presc_q, presc_d;
  logic              tick_q, tick_d;
  logic [NUM_CH-1:0] start_prev_q, start_prev_d;
  logic [NUM_CH-1:0] done_q, done_d;
  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [WIDTH-1:0]  rem_q   [NUM_CH];
  logic [WIDTH-1:0]  rem_d   [NUM_CH];
  logic [WIDTH-1:0]  rld_q   [NUM_CH];
  logic [WIDTH-1:0]  rld_d   [NUM_CH];

  logic [WIDTH-1:0]  dur_w   [NUM_CH];
  logic [NUM_CH-1:0] start_edge;

  // ---------------------------------------------------------------------------
  // Shared prescaler: free-running 0..TICK_DIV-1; tick is registered so it is
  // high for the one cycle after the counter sits at its terminal value.
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_ONE;
    tick_d  = (presc_q == PRESC_MAX);
  end

  // ---------------------------------------------------------------------------
  // Start edge detection. The history register resets to 0, so a start held
  // high across reset is seen as a fresh edge right after release.
  // ---------------------------------------------------------------------------
  assign start_prev_d = start;
  assign start_edge   = start & ~start_prev_q;

  // ---------------------------------------------------------------------------
  // Per-channel next-state logic. Priority: abort > start edge > pause > tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; otherwise a latch would be inferred.
    done_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k] = state_q[k];
      rem_d[k]   = rem_q[k];
      rld_d[k]   = rld_q[k];

      if (abort[k]) begin
        state_d[k] = ST_IDLE;
        rem_d[k]   = '0;
      end else if (start_edge[k] &&
                   ((state_q[k] == ST_IDLE) || (state_q[k] == ST_EXPIRED) ||
                    (RETRIGGER != 0))) begin
        // Fresh start, or retrigger of an active channel. A zero duration
        // expires immediately instead of parking in RUN with nothing to count.
        rld_d[k] = dur_w[k];
        if (dur_w[k] != '0) begin
          state_d[k] = ST_RUN;
          rem_d[k]   = dur_w[k];
        end else begin
          state_d[k] = ST_EXPIRED;
          rem_d[k]   = '0;
          done_d[k]  = 1'b1;
        end
      end else begin
        unique case (state_q[k])
          ST_RUN: begin
            if (pause[k]) begin
              // A tick in the same cycle is dropped: pause wins.
              state_d[k] = ST_PAUSE;
            end else if (tick_q) begin
              if (rem_q[k] > REM_ONE) begin
                rem_d[k] = rem_q[k] - REM_ONE;
              end else begin
                // Reaching zero: one-shot parks in EXPIRED, auto-reload
                // restarts from the value latched at the last start edge.
                done_d[k] = 1'b1;
                if (reload_mode[k]) begin
                  rem_d[k] = rld_q[k];
                end else begin
                  rem_d[k]   = '0;
                  state_d[k] = ST_EXPIRED;
                end
              end
            end
          end
          ST_PAUSE: begin
            // Ticks are ignored while paused; the release cycle only resumes.
            if (!pause[k]) state_d[k] = ST_RUN;
          end
          ST_EXPIRED: begin
            rem_d[k] = '0;
          end
          default: begin
            rem_d[k] = '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      presc_q      <= '0;
      tick_q       <= 1'b0;
      start_prev_q <= '0;
      done_q       <= '0;
      // NOTE: the per-channel arrays are small flop banks, not RAM, so they
      // are reset along with everything else to give defined outputs.
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= ST_IDLE;
        rem_q[k]   <= '0;
        rld_q[k]   <= '0;
      end
    end else begin
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      start_prev_q <= start_prev_d;
      done_q       <= done_d;
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        rem_q[k]   <= rem_d[k];
        rld_q[k]   <= rld_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Port packing and state-decoded outputs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign dur_w[g]                   = duration[g*WIDTH +: WIDTH];
    assign remaining[g*WIDTH +: WIDTH] = rem_q[g];
    assign on[g]        = (state_q[g] == ST_RUN) || (state_q[g] == ST_PAUSE);
    // In auto-reload mode the channel never enters EXPIRED, so the flag
    // stays at the value it had when the channel was started (cleared).
    assign t_expired[g] = (state_q[g] == ST_EXPIRED);
  end

  assign done_pulse = done_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_brew_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_brew_timer_bank
//
// Bench for brew_timer_bank with NUM_CH=2, WIDTH=4, TICK_DIV=4. Two instances
// share all inputs: one with RETRIGGER=0 (main) and one with RETRIGGER=1.
// Expected done_pulse events of the main instance are queued per channel when
// a start is issued and are popped and compared whenever the DUT pulses.
// -----------------------------------------------------------------------------
module tb_brew_timer_bank;

  localparam int NUM_CH   = 2;
  localparam int WIDTH    = 4;
  localparam int TICK_DIV = 4;

  typedef struct packed {
    logic       on;
    logic       t_exp;
    logic [3:0] rem;
  } done_exp_t;

  logic                    clk_100MHz = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       start, abort, pause, reload_mode;
  logic [NUM_CH*WIDTH-1:0] duration;

  logic [NUM_CH-1:0]       on, t_exp, done;
  logic [NUM_CH*WIDTH-1:0] rem;
  logic                    tick;

  logic [NUM_CH-1:0]       rt_on, rt_t_exp, rt_done;
  logic [NUM_CH*WIDTH-1:0] rt_rem;
  logic                    rt_tick;

  int checks = 0;
  int errors = 0;
  int on_cnt0 = 0;
  done_exp_t exp_q0[$];
  done_exp_t exp_q1[$];

  always #5 clk_100MHz = ~clk_100MHz;

  brew_timer_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TICK_DIV(TICK_DIV),
                    .RETRIGGER(0)) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .pause      (pause),
    .reload_mode(reload_mode),
    .duration   (duration),
    .on         (on),
    .t_expired  (t_exp),
    .done_pulse (done),
    .remaining  (rem),
    .tick       (tick)
  );

  brew_timer_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TICK_DIV(TICK_DIV),
                    .RETRIGGER(1)) dut_rt (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .pause      (pause),
    .reload_mode(reload_mode),
    .duration   (duration),
    .on         (rt_on),
    .t_expired  (rt_t_exp),
    .done_pulse (rt_done),
    .remaining  (rt_rem),
    .tick       (rt_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic done_exp_t mk(input logic o, input logic te,
                                   input logic [3:0] r);
    done_exp_t e;
    e.on = o; e.t_exp = te; e.rem = r;
    return e;
  endfunction

  // Advance one cycle to the next falling edge and score any done pulses.
  task automatic step();
    done_exp_t e;
    @(negedge clk_100MHz);
    if (on[0]) on_cnt0++;
    if (done[0]) begin
      if (exp_q0.size() == 0) check("done0_unexpected", 1, 0);
      else begin
        e = exp_q0.pop_front();
        check("done0_on",   on[0],    e.on);
        check("done0_texp", t_exp[0], e.t_exp);
        check("done0_rem",  rem[3:0], e.rem);
      end
    end
    if (done[1]) begin
      if (exp_q1.size() == 0) check("done1_unexpected", 1, 0);
      else begin
        e = exp_q1.pop_front();
        check("done1_on",   on[1],    e.on);
        check("done1_texp", t_exp[1], e.t_exp);
        check("done1_rem",  rem[7:4], e.rem);
      end
    end
  endtask

  // Step until tick is high at a falling edge (bounded).
  task automatic wait_tick();
    int n = 0;
    while (!tick && n < 20) begin
      step();
      n++;
    end
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  // Tick consumed, then look at the result one cycle later.
  task automatic after_tick();
    wait_tick();
    step();
  endtask

  task automatic start_ch(input int ch, input logic [3:0] dur);
    duration[ch*WIDTH +: WIDTH] = dur;
    start[ch] = 1'b1;
    step();
    start[ch] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = '0; abort = '0; pause = '0; reload_mode = '0;
    duration = '0;
    step(); step();

    // Reset state
    check("rst_on",   on,   0);
    check("rst_texp", t_exp, 0);
    check("rst_done", done, 0);
    check("rst_rem",  rem,  0);
    check("rst_tick", tick, 0);
    rst_n = 1'b1;
    step();

    // 1: one-shot ch0, duration 3
    exp_q0.push_back(mk(1'b0, 1'b1, 4'd0));
    start_ch(0, 4'd3);
    check("t1_on",  on[0],    1);
    check("t1_rem", rem[3:0], 3);
    after_tick(); check("t1_rem2", rem[3:0], 2);
    after_tick(); check("t1_rem1", rem[3:0], 1);
    after_tick(); check("t1_done", done[0],  1);
    step();
    check("t1_done_width", done[0],  0);
    check("t1_texp",       t_exp[0], 1);
    check("t1_off",        on[0],    0);
    check("t1_ch1_on",     on[1],    0);
    check("t1_ch1_rem",    rem[7:4], 0);

    // 2: ch0 duration 5 with a 3-tick pause mid-count
    exp_q0.push_back(mk(1'b0, 1'b1, 4'd0));
    on_cnt0 = 0;
    start_ch(0, 4'd5);
    check("t2_texp_clr", t_exp[0], 0);
    after_tick(); check("t2_rem4", rem[3:0], 4);
    after_tick(); check("t2_rem3", rem[3:0], 3);
    pause[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      after_tick();
      check("t2_frozen", rem[3:0], 3);
      check("t2_on_paused", on[0], 1);
    end
    pause[0] = 1'b0;
    after_tick(); check("t2_rem2", rem[3:0], 2);
    after_tick(); check("t2_rem1", rem[3:0], 1);
    after_tick(); check("t2_texp", t_exp[0], 1);
    check("t2_on_time", (on_cnt0 >= 28 && on_cnt0 <= 36), 1);

    // 3: ch1 auto-reload, duration 2, four periods then abort
    reload_mode[1] = 1'b1;
    for (int i = 0; i < 4; i++) exp_q1.push_back(mk(1'b1, 1'b0, 4'd2));
    start_ch(1, 4'd2);
    check("t3_rem", rem[7:4], 2);
    for (int i = 1; i <= 8; i++) begin
      after_tick();
      check("t3_rem_seq", rem[7:4], (i % 2) ? 1 : 2);
      check("t3_on",      on[1],    1);
      check("t3_texp",    t_exp[1], 0);
    end
    check("t3_periods", exp_q1.size(), 0);
    abort[1] = 1'b1;
    step();
    abort[1] = 1'b0;
    check("t3_abort_on",  on[1],    0);
    check("t3_abort_rem", rem[7:4], 0);
    reload_mode[1] = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // 4: abort clears t_expired, then duration 0 expires at once
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    check("t4_abort_texp", t_exp[0], 0);
    exp_q0.push_back(mk(1'b0, 1'b1, 4'd0));
    start_ch(0, 4'd0);
    check("t4_done", done[0],  1);
    check("t4_texp", t_exp[0], 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_never_on", on[0], 0);
    end

    // 5: second start edge at remaining=1, RETRIGGER=0 vs 1
    exp_q0.push_back(mk(1'b0, 1'b1, 4'd0));
    start_ch(0, 4'd3);
    after_tick();
    after_tick();
    check("t5_rem1",    rem[3:0],    1);
    check("t5_rt_rem1", rt_rem[3:0], 1);
    duration[3:0] = 4'd4;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check("t5_ignored",  rem[3:0],    1);
    check("t5_reloaded", rt_rem[3:0], 4);
    after_tick();
    check("t5_expired",  t_exp[0],    1);
    check("t5_rt_rem3",  rt_rem[3:0], 3);
    check("t5_rt_on",    rt_on[0],    1);
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;

    // 6a: abort and start edge in the same cycle -> abort wins
    duration[3:0] = 4'd5;
    start[0] = 1'b1;
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    check("t6_on",   on[0],    0);
    check("t6_rem",  rem[3:0], 0);
    check("t6_texp", t_exp[0], 0);
    step();
    check("t6_no_edge", on[0], 0);
    start[0] = 1'b0;
    step();

    // 6b: reset mid-count with start held through reset
    start_ch(0, 4'd5);
    start_ch(1, 4'd3);
    after_tick();
    check("t6_rem0", rem[3:0], 4);
    check("t6_rem1", rem[7:4], 2);
    start[0] = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    check("t6_rst_on",   on,    0);
    check("t6_rst_texp", t_exp, 0);
    check("t6_rst_done", done,  0);
    check("t6_rst_rem",  rem,   0);
    check("t6_rst_tick", tick,  0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_held_on",  on[0],    1);
    check("t6_held_rem", rem[3:0], 5);
    check("t6_ch1_idle", on[1],    0);
    check("t6_tick0",    tick,     0);
    n = 1;
    while (!tick && n < 20) begin
      step();
      n++;
    end
    check("t6_tick_phase", n, 4);
    start[0] = 1'b0;
    abort = '1;
    step();
    abort = '0;
    step();

    check("left_exp0", exp_q0.size(), 0);
    check("left_exp1", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brew_timer_bank.md
Name: brew_timer_bank

Overview:
- Multi-channel countdown timer bank for the coffee-maker controller; one channel per brew resource (heater, pump, grinder, ...).
- A single shared prescaler derives a 1 s tick from the system clock; each channel counts a per-start duration down to zero.
- Each channel drives its actuator-enable ("on") and a sticky expiry flag to the control FSM.
- Adds over the single-channel timer: parametrised width/channels, pause, abort, auto-reload mode, remaining-time readback, optional retrigger.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..16).
- WIDTH, 8, bits of the per-channel duration/remaining counter, in ticks.
- TICK_DIV, 100_000_000, clk_100MHz cycles per tick; must be ≥ 2.
- RETRIGGER, 0, 1 = a start edge while running reloads the duration; 0 = the start edge is ignored.

Ports:
- clk_100MHz  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  NUM_CH  per-channel start request; the rising edge is detected internally.
- abort  in  NUM_CH  per-channel abort, level; returns the channel to IDLE.
- pause  in  NUM_CH  per-channel pause, level; freezes the countdown.
- reload_mode  in  NUM_CH  1 = auto-reload at zero; 0 = one-shot.
- duration  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]; sampled on the start edge.
- on  out  NUM_CH  channel active (RUN or PAUSE).
- t_expired  out  NUM_CH  sticky expiry flag for one-shot channels.
- done_pulse  out  NUM_CH  one-cycle pulse each time a channel reaches zero.
- remaining  out  NUM_CH*WIDTH  current remaining ticks, same packing as duration.
- tick  out  1  shared prescaler tick; one cycle high every TICK_DIV cycles.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - prescaler counter = 0; all channels in IDLE.
  - on, t_expired, done_pulse, remaining, tick = 0.
  - start-edge history registers = 0, so a start held high through reset counts as an edge after release.
- Prescaler:
  - ceil(log2 TICK_DIV)-bit counter, free-running from reset, counts 0..TICK_DIV-1 and wraps.
  - tick is registered and is high for the one cycle after the counter equals TICK_DIV-1.
  - Shared by all channels; the first tick after a start can arrive 1..TICK_DIV cycles later (±1 tick accuracy, by design).
- Start edge: start_k=1 with the previous sample 0, evaluated every cycle.
- Per-channel FSM states: IDLE, RUN, PAUSE, EXPIRED.
  - IDLE/EXPIRED + start edge, duration≠0:
    - latch duration into the reload register and into remaining.
    - clear t_expired; go to RUN; on=1 from the next cycle.
  - IDLE/EXPIRED + start edge, duration=0: go to EXPIRED next cycle, t_expired=1, done_pulse=1 for one cycle, on stays 0.
  - RUN + tick + pause=0:
    - if remaining>1, decrement remaining.
    - if remaining=1, remaining:=0, done_pulse=1, then:
      - reload_mode=0: go to EXPIRED, on=0, t_expired=1.
      - reload_mode=1: remaining:=reload register, stay in RUN, t_expired unchanged.
  - RUN + pause=1: go to PAUSE; a tick in the same cycle is ignored.
  - PAUSE + pause=0: return to RUN; ticks are ignored while in PAUSE; on stays 1; remaining is frozen.
  - RUN/PAUSE + start edge:
    - RETRIGGER=1: reload remaining from duration and go to RUN.
    - RETRIGGER=0: no effect.
  - EXPIRED: holds t_expired=1, on=0, remaining=0 until a start edge or abort.
- Abort:
  - abort_k=1 in any state → IDLE next cycle; on, t_expired, remaining for channel k cleared; no done_pulse.
- Priority per channel, same cycle: rst_n > abort > start edge > pause > tick.
- Channels are fully independent; simultaneous expiries on different channels each produce their own done_pulse in the same cycle.
- Arithmetic: remaining never wraps below 0; a duration of 2^WIDTH-1 is valid.
- Latency:
  - start edge → on=1: 1 cycle.
  - the tick that zeroes remaining → done_pulse/t_expired/on=0: visible the following cycle.
- Reset mid-operation returns everything to the reset values above; the prescaler phase restarts at 0.

Test Plan:
- NUM_CH=2, WIDTH=4, TICK_DIV=4; reset, then start ch0 with duration=3, reload_mode=0 → on[0]=1 after 1 cycle; remaining steps 3,2,1,0 on successive ticks; done_pulse[0] for exactly 1 cycle; t_expired[0]=1; on[0]=0; ch1 untouched.
- ch0 duration=5, pause high for 3 ticks mid-count → remaining frozen while paused; total on-time = 8 ticks ±1; expiry as above.
- ch1 reload_mode=1, duration=2 → done_pulse[1] every 2 ticks for 4 periods; on[1] held at 1; t_expired[1] stays 0; abort[1] → on=0, remaining=0, no done_pulse.
- Start with duration=0 → t_expired=1 and done_pulse on the next cycle; on never asserts.
- RETRIGGER=0 vs 1: second start edge at remaining=1 → ignored (expires on the next tick) vs reloaded to the new duration=4.
- Abort and start edge in the same cycle, and rst_n low mid-count → channel in IDLE with all outputs 0; after rst_n releases, a held start is treated as a new edge and starts the channel.
